// File: rtl/spi_quad_slave_top.sv
// SPI loop-back core: one master and four slaves joined by an internal SCLK/MOSI/MISO bus.
// Define SPI_LSB_FIRST_EN to shift LSB first on the bus; received words keep natural bit order.
module spi_quad_slave_top #(
    parameter logic [1:0] mode     = 2'b00,
    parameter int         bits_num = 8,
    parameter int         clk_div  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [1:0]          sel,
    input  logic [bits_num-1:0] master_data_in,
    input  logic [bits_num-1:0] slave1_data_in,
    input  logic [bits_num-1:0] slave2_data_in,
    input  logic [bits_num-1:0] slave3_data_in,
    input  logic [bits_num-1:0] slave4_data_in,
    output logic                tx_end,
    output logic [bits_num-1:0] master_data_out,
    output logic [bits_num-1:0] slave1_data_out,
    output logic [bits_num-1:0] slave2_data_out,
    output logic [bits_num-1:0] slave3_data_out,
    output logic [bits_num-1:0] slave4_data_out
);

    localparam logic CPOL = mode[1];
    localparam logic CPHA = mode[0];
    localparam int   EW   = $clog2(2 * bits_num + 1);
    localparam int   DW   = $clog2(clk_div);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * bits_num);
    localparam logic [DW-1:0] DIV_TOP   = DW'(clk_div - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_DONE
    } state_t;

    function automatic logic out_bit(input logic [bits_num-1:0] sr);
`ifdef SPI_LSB_FIRST_EN
        return sr[0];
`else
        return sr[bits_num-1];
`endif
    endfunction

    function automatic logic [bits_num-1:0] shift_in(input logic [bits_num-1:0] sr,
                                                     input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, sr[bits_num-1:1]};
`else
        return {sr[bits_num-2:0], b};
`endif
    endfunction

    // Master / frame control
    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [DW-1:0]       div_q, div_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic                sclk_q, sclk_d, sclk_prev_q;
    logic                mosi_q, mosi_d;
    logic                miso;
    logic [bits_num-1:0] m_sr_q, m_sr_d;
    logic [bits_num-1:0] mdo_q, mdo_d;
    logic [3:0]          ss_n_q, ss_n_d, ss_prev_q;
    logic                tx_end_q, tx_end_d;
    logic                frame_end;

    // Slave engines
    logic [bits_num-1:0] s_din [4];
    logic [bits_num-1:0] s_sr_q [4];
    logic [bits_num-1:0] s_sr_d [4];
    logic [bits_num-1:0] sdo_q [4];
    logic [bits_num-1:0] sdo_d [4];
    logic [3:0]          s_miso_q, s_miso_d;
    logic                s_edge, s_lead, s_sample, s_shift;

    assign s_din[0] = slave1_data_in;
    assign s_din[1] = slave2_data_in;
    assign s_din[2] = slave3_data_in;
    assign s_din[3] = slave4_data_in;

    assign frame_end = (state_q == ST_XFER) && (edge_q == LAST_EDGE);
    // Captured select drives the MISO mux so a live sel change cannot corrupt the frame
    assign miso      = s_miso_q[sel_q];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        div_d    = div_q;
        edge_d   = edge_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        m_sr_d   = m_sr_q;
        mdo_d    = mdo_q;
        ss_n_d   = ss_n_q;
        tx_end_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d = ST_LOAD;
                    sel_d   = sel;
                    m_sr_d  = master_data_in;
                    ss_n_d  = ~(4'b0001 << sel);
                end
            end
            ST_LOAD: begin
                state_d = ST_XFER;
                div_d   = '0;
                edge_d  = '0;
                if (!CPHA) begin
                    mosi_d = out_bit(m_sr_q);
                end
            end
            ST_XFER: begin
                if (frame_end) begin
                    state_d  = ST_DONE;
                    ss_n_d   = 4'hF;
                    mosi_d   = 1'b0;
                    tx_end_d = 1'b1;
                    mdo_d    = m_sr_q;
                end else if (div_q == DIV_TOP) begin
                    div_d  = '0;
                    edge_d = edge_q + EW'(1);
                    sclk_d = ~sclk_q;
                    // Even edge indices are leading edges
                    if (edge_q[0] == CPHA) begin
                        m_sr_d = shift_in(m_sr_q, miso);
                    end else begin
                        mosi_d = out_bit(m_sr_q);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slaves see SCLK edges one clk later, through their own edge detector
    assign s_edge   = sclk_q ^ sclk_prev_q;
    assign s_lead   = s_edge & (sclk_q ^ CPOL);
    assign s_sample = s_edge & (s_lead ^ CPHA);
    assign s_shift  = s_edge & ~s_sample;

    always_comb begin
        s_miso_d = s_miso_q;
        for (int k = 0; k < 4; k++) begin
            s_sr_d[k] = s_sr_q[k];
            sdo_d[k]  = sdo_q[k];
            if (ss_n_q[k]) begin
                s_miso_d[k] = 1'b0;
                if ((state_q == ST_IDLE) && tx_start && (sel == 2'(k))) begin
                    s_sr_d[k] = s_din[k];
                end
            end else if (ss_prev_q[k]) begin
                if (!CPHA) begin
                    s_miso_d[k] = out_bit(s_sr_q[k]);
                end
            end else if (s_sample) begin
                s_sr_d[k] = shift_in(s_sr_q[k], mosi_q);
            end else if (s_shift) begin
                s_miso_d[k] = out_bit(s_sr_q[k]);
            end
            // CPHA=1 slaves take their last bit on the frame-end cycle, so capture next state
            if (frame_end && (sel_q == 2'(k))) begin
                sdo_d[k] = s_sr_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'b00;
            div_q       <= '0;
            edge_q      <= '0;
            sclk_q      <= CPOL;
            sclk_prev_q <= CPOL;
            mosi_q      <= 1'b0;
            m_sr_q      <= '0;
            mdo_q       <= '0;
            ss_n_q      <= 4'hF;
            ss_prev_q   <= 4'hF;
            tx_end_q    <= 1'b0;
            s_miso_q    <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                s_sr_q[k] <= '0;
                sdo_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            div_q       <= div_d;
            edge_q      <= edge_d;
            sclk_q      <= sclk_d;
            sclk_prev_q <= sclk_q;
            mosi_q      <= mosi_d;
            m_sr_q      <= m_sr_d;
            mdo_q       <= mdo_d;
            ss_n_q      <= ss_n_d;
            ss_prev_q   <= ss_n_q;
            tx_end_q    <= tx_end_d;
            s_miso_q    <= s_miso_d;
            for (int k = 0; k < 4; k++) begin
                s_sr_q[k] <= s_sr_d[k];
                sdo_q[k]  <= sdo_d[k];
            end
        end
    end

    assign tx_end          = tx_end_q;
    assign master_data_out = mdo_q;
    assign slave1_data_out = sdo_q[0];
    assign slave2_data_out = sdo_q[1];
    assign slave3_data_out = sdo_q[2];
    assign slave4_data_out = sdo_q[3];

endmodule

// File: tb/tb_spi_quad_slave_top.sv
// Directed bench for spi_quad_slave_top: one instance per SPI mode, all driven by the same stimulus.
module tb_spi_quad_slave_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [1:0] sel;
    logic [7:0] mdi;
    logic [7:0] sdi [4];

    logic       tx_end_w [4];
    logic [7:0] mdo_w [4];
    logic [7:0] sdo_w [4][4];
    logic [3:0] ss_w [4];

    logic [7:0] exp_sdo [4];
    int         lat [4];
    int         npulse [4];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        spi_quad_slave_top #(.mode(2'(g)), .bits_num(8), .clk_div(4)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .tx_start       (tx_start),
            .sel            (sel),
            .master_data_in (mdi),
            .slave1_data_in (sdi[0]),
            .slave2_data_in (sdi[1]),
            .slave3_data_in (sdi[2]),
            .slave4_data_in (sdi[3]),
            .tx_end         (tx_end_w[g]),
            .master_data_out(mdo_w[g]),
            .slave1_data_out(sdo_w[g][0]),
            .slave2_data_out(sdo_w[g][1]),
            .slave3_data_out(sdo_w[g][2]),
            .slave4_data_out(sdo_w[g][3])
        );
        assign ss_w[g] = u_dut.ss_n_q;
    end

    // Start one frame and watch tx_end for `window` cycles after the sampling edge.
    task automatic do_frame(input logic [1:0] s, input bit disturb, input int window);
        for (int g = 0; g < 4; g++) begin
            lat[g]    = -1;
            npulse[g] = 0;
        end
        @(negedge clk);
        sel      = s;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 1; c <= window; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (tx_end_w[g] === 1'b1) begin
                    npulse[g]++;
                    if (lat[g] < 0) lat[g] = c;
                end
            end
            if (disturb && c == 20) begin
                sel      = ~s;
                mdi      = 8'h00;
                for (int k = 0; k < 4; k++) sdi[k] = 8'hFF;
                tx_start = 1'b1;
            end
            if (disturb && c == 21) tx_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_start = 1'b0;
        sel      = 2'b00;
        mdi      = 8'h00;
        for (int k = 0; k < 4; k++) begin
            sdi[k]     = 8'h00;
            exp_sdo[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (tx_end_w[g] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_tx_end mode%0d: got %b want 0", g, tx_end_w[g]);
            end
            n_cmp++;
            if (mdo_w[g] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_mdo mode%0d: got %h want 00", g, mdo_w[g]);
            end
            n_cmp++;
            if (ss_w[g] !== 4'hF) begin
                n_err++;
                $display("FAIL reset_ss_n mode%0d: got %h want f", g, ss_w[g]);
            end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (sdo_w[g][k] !== 8'h00) begin
                    n_err++;
                    $display("FAIL reset_sdo%0d mode%0d: got %h want 00", k + 1, g, sdo_w[g][k]);
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sel_sweep(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d);
        logic [7:0] sv [4];
        sv[0] = a; sv[1] = b; sv[2] = c; sv[3] = d;
        mdi = m;
        for (int k = 0; k < 4; k++) sdi[k] = sv[k];
        for (int s = 0; s < 4; s++) begin
            do_frame(2'(s), 1'b0, 120);
            exp_sdo[s] = m;
            for (int g = 0; g < 4; g++) begin
                n_cmp++;
                if (lat[g] != 66) begin
                    n_err++;
                    $display("FAIL sweep_latency sel%0d mode%0d: got %0d want 66", s, g, lat[g]);
                end
                n_cmp++;
                if (npulse[g] != 1) begin
                    n_err++;
                    $display("FAIL sweep_pulses sel%0d mode%0d: got %0d want 1", s, g, npulse[g]);
                end
                n_cmp++;
                if (mdo_w[g] !== sv[s]) begin
                    n_err++;
                    $display("FAIL sweep_mdo sel%0d mode%0d: got %h want %h", s, g, mdo_w[g], sv[s]);
                end
                for (int k = 0; k < 4; k++) begin
                    n_cmp++;
                    if (sdo_w[g][k] !== exp_sdo[k]) begin
                        n_err++;
                        $display("FAIL sweep_sdo%0d sel%0d mode%0d: got %h want %h",
                                 k + 1, s, g, sdo_w[g][k], exp_sdo[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_midframe();
        mdi    = 8'h5C;
        sdi[0] = 8'h11; sdi[1] = 8'h22; sdi[2] = 8'h33; sdi[3] = 8'h44;
        do_frame(2'b10, 1'b1, 150);
        exp_sdo[2] = 8'h5C;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (lat[g] != 66 || npulse[g] != 1) begin
                n_err++;
                $display("FAIL mid_tx_end mode%0d: got lat %0d pulses %0d want lat 66 pulses 1",
                         g, lat[g], npulse[g]);
            end
            n_cmp++;
            if (mdo_w[g] !== 8'h33) begin
                n_err++;
                $display("FAIL mid_mdo mode%0d: got %h want 33", g, mdo_w[g]);
            end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (sdo_w[g][k] !== exp_sdo[k]) begin
                    n_err++;
                    $display("FAIL mid_sdo%0d mode%0d: got %h want %h", k + 1, g, sdo_w[g][k], exp_sdo[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int pulses [4];
        mdi    = 8'hA5;
        sdi[0] = 8'h01; sdi[1] = 8'h02; sdi[2] = 8'h03; sdi[3] = 8'h3C;
        for (int g = 0; g < 4; g++) pulses[g] = 0;
        @(negedge clk);
        sel      = 2'b11;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) if (tx_end_w[g] === 1'b1) pulses[g]++;
        end
        reset = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (ss_w[g] !== 4'hF || tx_end_w[g] !== 1'b0 || mdo_w[g] !== 8'h00) begin
                n_err++;
                $display("FAIL rstmid_ctrl mode%0d: got ss %h tx_end %b mdo %h want f 0 00",
                         g, ss_w[g], tx_end_w[g], mdo_w[g]);
            end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (sdo_w[g][k] !== 8'h00) begin
                    n_err++;
                    $display("FAIL rstmid_sdo%0d mode%0d: got %h want 00", k + 1, g, sdo_w[g][k]);
                end
            end
        end
        for (int k = 0; k < 4; k++) exp_sdo[k] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) if (tx_end_w[g] === 1'b1) pulses[g]++;
        end
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (pulses[g] != 0) begin
                n_err++;
                $display("FAIL rstmid_no_tx_end mode%0d: got %0d pulses want 0", g, pulses[g]);
            end
        end
        do_frame(2'b11, 1'b0, 120);
        exp_sdo[3] = 8'hA5;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (lat[g] != 66 || mdo_w[g] !== 8'h3C || sdo_w[g][3] !== 8'hA5) begin
                n_err++;
                $display("FAIL rstmid_next mode%0d: got lat %0d mdo %h sdo4 %h want 66 3c a5",
                         g, lat[g], mdo_w[g], sdo_w[g][3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1 [4];
        int t2 [4];
        int cnt [4];
        mdi    = 8'hE7;
        sdi[0] = 8'h10; sdi[1] = 8'h6D; sdi[2] = 8'h30; sdi[3] = 8'h40;
        for (int g = 0; g < 4; g++) begin
            t1[g] = -1; t2[g] = -1; cnt[g] = 0;
        end
        @(negedge clk);
        sel      = 2'b01;
        tx_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 220; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (tx_end_w[g] === 1'b1) begin
                    cnt[g]++;
                    if (t1[g] < 0) t1[g] = c;
                    else if (t2[g] < 0) t2[g] = c;
                end
            end
            if (c == 134) tx_start = 1'b0;
        end
        exp_sdo[1] = 8'hE7;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (t1[g] != 66 || t2[g] != 134 || cnt[g] != 2) begin
                n_err++;
                $display("FAIL b2b_timing mode%0d: got t1 %0d t2 %0d n %0d want 66 134 2",
                         g, t1[g], t2[g], cnt[g]);
            end
            n_cmp++;
            if (mdo_w[g] !== 8'h6D || sdo_w[g][1] !== 8'hE7) begin
                n_err++;
                $display("FAIL b2b_data mode%0d: got mdo %h sdo2 %h want 6d e7", g, mdo_w[g], sdo_w[g][1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel_sweep(8'hAB, 8'hC8, 8'h2A, 8'hF5, 8'hB9);
        test_sel_sweep(8'h29, 8'h92, 8'h0D, 8'hFE, 8'h1E);
        test_midframe();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
